// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST classifier datapath: default sizes,
// the classifier state encoding and a constant-friendly clog2 helper.
package mnist_pkg;

  // Default datapath sizes (32 channels x 7 x 7 features, 10 digits).
  localparam int IntSize     = 8;
  localparam int FEAT_LEN    = 1568;
  localparam int NUM_CLASSES = 10;

  // Classifier sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_u8s8.sv
// Combinational multiply-accumulate: unsigned activation times signed
// weight, sign-extended and added to a signed accumulator. No registers,
// so the caller owns the accumulator state.
module mac_u8s8
  import mnist_pkg::*;
#(
  parameter int IntSize = mnist_pkg::IntSize,
  parameter int ACC_W   = 28
) (
  input  logic                      [IntSize-1:0] feature,
  input  logic                      [IntSize-1:0] weight,
  input  logic signed               [ACC_W-1:0]   acc_in,
  output logic signed               [ACC_W-1:0]   acc_out
);

  localparam int PROD_W = 2 * IntSize + 1;

  logic signed [PROD_W-1:0] feat_ext_s;
  logic signed [PROD_W-1:0] wgt_ext_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_acc_s;

  // Widen both operands to the full product width so the multiply is
  // exact: the activation is zero-extended, the weight sign-extended.
  always_comb begin
    feat_ext_s = {{(IntSize + 1){1'b0}}, feature};
    wgt_ext_s  = {{(IntSize + 1){weight[IntSize-1]}}, weight};
    prod_s     = feat_ext_s * wgt_ext_s;
  end

  // Sign-extend the product and add; the sum wraps if ACC_W is undersized.
  always_comb begin
    prod_acc_s = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
    acc_out    = acc_in + prod_acc_s;
  end

endmodule

// File: rtl/dense_argmax.sv
// Final classifier stage: streams class-major feature/weight pairs,
// accumulates one dot product per class and tracks the running argmax.
// Outputs are either registers or decodes of the state register, so no
// input reaches an output combinationally.
module dense_argmax
  import mnist_pkg::*;
#(
  parameter int IntSize     = mnist_pkg::IntSize,
  parameter int FEAT_LEN    = mnist_pkg::FEAT_LEN,
  parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
  parameter int ACC_W       = 28
) (
  input  logic               FSM_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IntSize-1:0] feature,
  input  logic [IntSize-1:0] weight,
  output logic               busy,
  output logic               number_valid,
  output logic [3:0]         answer,
  output logic [ACC_W-1:0]   max_score
);

  // A one-feature vector would give a zero-width counter; keep at least 1 bit.
  localparam int IDX_W = (clog2(FEAT_LEN) < 1) ? 1 : clog2(FEAT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FEAT_LEN - 1);
  localparam logic [3:0]       CLASS_LAST = 4'(NUM_CLASSES - 1);

  state_t                   state_r;
  state_t                   state_nx_s;
  logic [IDX_W-1:0]         idx_r;
  logic [IDX_W-1:0]         idx_nx_s;
  logic [3:0]               class_r;
  logic [3:0]               class_nx_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_nx_s;
  logic signed [ACC_W-1:0]  max_r;
  logic signed [ACC_W-1:0]  max_nx_s;
  logic [3:0]               answer_r;
  logic [3:0]               answer_nx_s;
  logic signed [ACC_W-1:0]  mac_out_s;
  logic                     better_s;

  mac_u8s8 #(
    .IntSize (IntSize),
    .ACC_W   (ACC_W)
  ) u_mac (
    .feature (feature),
    .weight  (weight),
    .acc_in  (acc_r),
    .acc_out (mac_out_s)
  );

  // Class 0 always seeds the maximum; later classes must strictly beat it,
  // so a tie keeps the lower class index.
  always_comb begin
    better_s = 1'b0;
    if (class_r == 4'd0) begin
      better_s = 1'b1;
    end else if (acc_r > max_r) begin
      better_s = 1'b1;
    end else begin
      better_s = 1'b0;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    class_nx_s  = class_r;
    acc_nx_s    = acc_r;
    max_nx_s    = max_r;
    answer_nx_s = answer_r;
    case (state_r)
      IDLE, DONE: begin
        // A pair offered alongside start is never taken: in_ready is low here.
        if (start) begin
          state_nx_s = ACCUM;
          idx_nx_s   = '0;
          class_nx_s = 4'd0;
          acc_nx_s   = '0;
        end else begin
          state_nx_s = state_r;
        end
      end
      ACCUM: begin
        // start is deliberately ignored while a run is in progress.
        if (in_valid) begin
          acc_nx_s = mac_out_s;
          if (idx_r == IDX_LAST) begin
            idx_nx_s   = '0;
            state_nx_s = COMPARE;
          end else begin
            idx_nx_s = idx_r + IDX_W'(1'b1);
          end
        end else begin
          state_nx_s = ACCUM;
        end
      end
      COMPARE: begin
        if (better_s) begin
          max_nx_s    = acc_r;
          answer_nx_s = class_r;
        end else begin
          max_nx_s = max_r;
        end
        if (class_r == CLASS_LAST) begin
          state_nx_s = DONE;
        end else begin
          class_nx_s = class_r + 4'd1;
          idx_nx_s   = '0;
          acc_nx_s   = '0;
          state_nx_s = ACCUM;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial run.
  always_ff @(posedge FSM_clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      class_r  <= 4'd0;
      acc_r    <= '0;
      max_r    <= '0;
      answer_r <= 4'd0;
    end else begin
      state_r  <= state_nx_s;
      idx_r    <= idx_nx_s;
      class_r  <= class_nx_s;
      acc_r    <= acc_nx_s;
      max_r    <= max_nx_s;
      answer_r <= answer_nx_s;
    end
  end

  // Handshake and status are pure decodes of the state register.
  always_comb begin
    in_ready     = (state_r == ACCUM);
    busy         = (state_r == ACCUM) || (state_r == COMPARE);
    number_valid = (state_r == DONE);
    answer       = answer_r;
    max_score    = max_r;
  end

endmodule

// File: tb/tb_dense_argmax.sv
// Scoreboard bench for dense_argmax with a 4-feature vector: stimulus pushes
// the hand-computed result of each run, a monitor pops and compares when
// number_valid rises and also measures start-to-done latency.
module tb_dense_argmax;

  localparam int F   = 4;
  localparam int ACC = 28;

  logic            FSM_clk = 1'b0;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      feature;
  logic [7:0]      weight;
  logic            busy;
  logic            number_valid;
  logic [3:0]      answer;
  logic [ACC-1:0]  max_score;

  dense_argmax #(
    .IntSize     (8),
    .FEAT_LEN    (F),
    .NUM_CLASSES (10),
    .ACC_W       (ACC)
  ) dut (
    .FSM_clk      (FSM_clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .feature      (feature),
    .weight       (weight),
    .busy         (busy),
    .number_valid (number_valid),
    .answer       (answer),
    .max_score    (max_score)
  );

  always #5 FSM_clk = ~FSM_clk;

  typedef struct {
    int ans;
    int score;
    int lat;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] ft [F];
  logic [7:0] wt [10][F];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: count falling edges, note when busy rises, score each result.
  int   ncount  = 0;
  int   start_n = 0;
  logic busy_q  = 1'b0;
  logic nv_q    = 1'b0;
  exp_t e;
  always @(negedge FSM_clk) begin
    ncount <= ncount + 1;
    if (busy && !busy_q) start_n <= ncount;
    if (number_valid && !nv_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", number_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("answer", answer, e.ans);
        check("max_score", $signed(max_score), e.score);
        check("latency", ncount - start_n, e.lat);
      end
    end
    busy_q <= busy;
    nv_q   <= number_valid;
  end

  task automatic fill(input logic [7:0] f, input logic [7:0] w);
    for (int i = 0; i < F; i++) ft[i] = f;
    for (int c = 0; c < 10; c++)
      for (int i = 0; i < F; i++) wt[c][i] = w;
  endtask

  task automatic set_class(input int c, input logic [7:0] w);
    for (int i = 0; i < F; i++) wt[c][i] = w;
  endtask

  // Pulse start; optionally offer a junk pair in the same cycle.
  task automatic start_run(input bit junk);
    @(negedge FSM_clk);
    check("idle_in_ready", in_ready, 0);
    start = 1'b1;
    if (junk) begin
      in_valid = 1'b1;
      feature  = 8'hFF;
      weight   = 8'h7F;
    end
    @(posedge FSM_clk);
    #1;
    check("start_busy", busy, 1);
    check("start_nv_low", number_valid, 0);
  endtask

  task automatic wait_ready();
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge FSM_clk);
      g++;
    end
  endtask

  // Offer one pair; in stall mode spend one ACCUM cycle with in_valid low first.
  task automatic send_pair(input logic [7:0] f, input logic [7:0] w,
                           input bit stall, input bit pulse);
    @(negedge FSM_clk);
    start = 1'b0;
    if (stall) begin
      in_valid = 1'b0;
      wait_ready();
      start = pulse;
      @(negedge FSM_clk);
      start = 1'b0;
    end
    feature  = f;
    weight   = w;
    in_valid = 1'b1;
    wait_ready();
    check("in_ready", in_ready, 1);
    @(posedge FSM_clk);
  endtask

  task automatic run_stream(input bit stall, input int abort_cls, input int abort_idx);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < F; i++) begin
        if (c == abort_cls && i == abort_idx) return;
        send_pair(ft[i], wt[c][i], stall, stall && c == 3 && i == 1);
      end
    end
    @(negedge FSM_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!number_valid && g < 200) begin
      @(negedge FSM_clk);
      g++;
    end
    check("done_reached", number_valid, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; feature = 8'd0; weight = 8'd0;
    repeat (2) @(negedge FSM_clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_nv", number_valid, 0);
    check("rst_answer", answer, 0);
    check("rst_max", $signed(max_score), 0);
    reset = 1'b0;

    // Class 7 wins with 4*5 = 20; others score 4.
    fill(8'd1, 8'd1); set_class(7, 8'd5);
    exp_q.push_back('{ans: 7, score: 20, lat: 50});
    start_run(1'b0); run_stream(1'b0, 99, 0); wait_done();

    // Classes 2 and 5 tie at 2*5*4 = 40, others 8: lower index kept. Restart from DONE.
    fill(8'd2, 8'd1); set_class(2, 8'd5); set_class(5, 8'd5);
    exp_q.push_back('{ans: 2, score: 40, lat: 50});
    start_run(1'b0); run_stream(1'b0, 99, 0); wait_done();

    // All negative: class 9 = -4, others -400. Junk pair offered with start.
    fill(8'd1, -8'sd100); set_class(9, -8'sd1);
    exp_q.push_back('{ans: 9, score: -4, lat: 50});
    start_run(1'b1); run_stream(1'b0, 99, 0); wait_done();

    // Class 0 = 255*-128*4 = -130560; class 1 scores 0 and wins, 2..9 tie at 0.
    fill(8'd255, 8'd0); set_class(0, -8'sd128);
    exp_q.push_back('{ans: 1, score: 0, lat: 50});
    start_run(1'b0); run_stream(1'b0, 99, 0); wait_done();

    // Same data as the first run with one idle cycle per pair and a stray start.
    fill(8'd1, 8'd1); set_class(7, 8'd5);
    exp_q.push_back('{ans: 7, score: 20, lat: 90});
    start_run(1'b0); run_stream(1'b1, 99, 0); wait_done();

    // Abort in class 4 ACCUM after answer=2/max=40 are loaded; no result expected.
    fill(8'd2, 8'd1); set_class(2, 8'd5); set_class(5, 8'd5);
    start_run(1'b0); run_stream(1'b0, 4, 2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_nv", number_valid, 0);
    check("mid_rst_answer", answer, 0);
    check("mid_rst_max", $signed(max_score), 0);
    @(negedge FSM_clk);
    in_valid = 1'b0;
    reset = 1'b0;

    // Fresh run after reset with the all-negative data.
    fill(8'd1, -8'sd100); set_class(9, -8'sd1);
    exp_q.push_back('{ans: 9, score: -4, lat: 50});
    start_run(1'b0); run_stream(1'b0, 99, 0); wait_done();

    repeat (3) @(negedge FSM_clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
